// File: rtl/exec_branch_unit.sv
// Execute/branch slice of the 16-bit single-cycle CPU: PC register, ALU and branch comparator.
// Optional build macro PC_REL_BRANCH_EN makes branch targets relative to the branch's own PC.
module exec_branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_ctrl,
    input  logic [15:0] alu_a,
    input  logic [15:0] alu_b,
    input  logic [2:0]  jump_op,
    input  logic [15:0] cmp_a,
    input  logic [15:0] cmp_b,
    input  logic [15:0] target_in,
    output logic [15:0] pc_out,
    output logic [15:0] alu_result,
    output logic        alu_zero,
    output logic        branch_taken,
    output logic [15:0] branch_target
);

    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [3:0]  w_shamt;
    logic        w_alu_slt;
    logic        w_alu_sltu;
    logic        w_cmp_eq;
    logic        w_cmp_lt;
    logic        w_cmp_ltu;

    assign w_shamt    = alu_b[3:0];
    assign w_alu_slt  = $signed(alu_a) < $signed(alu_b);
    assign w_alu_sltu = alu_a < alu_b;

    always_comb begin
        alu_result = 16'h0000;
        case (alu_ctrl)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = ~alu_a;
            4'd6:    alu_result = alu_a << w_shamt;
            4'd7:    alu_result = alu_a >> w_shamt;
            4'd8:    alu_result = $signed(alu_a) >>> w_shamt;
            4'd9:    alu_result = {15'd0, w_alu_slt};
            4'd10:   alu_result = {15'd0, w_alu_sltu};
            4'd11:   alu_result = alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    assign alu_zero = (alu_result == 16'h0000);

    assign w_cmp_eq  = (cmp_a == cmp_b);
    assign w_cmp_lt  = $signed(cmp_a) < $signed(cmp_b);
    assign w_cmp_ltu = cmp_a < cmp_b;

    always_comb begin
        branch_taken = 1'b0;
        case (jump_op)
            3'd1:    branch_taken = 1'b1;
            3'd2:    branch_taken = w_cmp_eq;
            3'd3:    branch_taken = ~w_cmp_eq;
            3'd4:    branch_taken = w_cmp_lt;
            3'd5:    branch_taken = ~w_cmp_lt;
            3'd6:    branch_taken = w_cmp_ltu;
            3'd7:    branch_taken = ~w_cmp_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

`ifdef PC_REL_BRANCH_EN
    assign branch_target = r_pc + target_in;
`else
    assign branch_target = target_in;
`endif

    // Word-addressed PC; increment wraps silently at 16'hFFFF.
    assign w_pc_next = branch_taken ? branch_target : (r_pc + 16'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= 16'h0000;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc_out = r_pc;

endmodule

// File: tb/tb_exec_branch_unit.sv
// Directed self-checking bench for exec_branch_unit; honours PC_REL_BRANCH_EN when defined.
module tb_exec_branch_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  jump_op;
    logic [15:0] cmp_a;
    logic [15:0] cmp_b;
    logic [15:0] target_in;
    logic [15:0] pc_out;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        branch_taken;
    logic [15:0] branch_target;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] pc_model;

    exec_branch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .alu_ctrl      (alu_ctrl),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .jump_op       (jump_op),
        .cmp_a         (cmp_a),
        .cmp_b         (cmp_b),
        .target_in     (target_in),
        .pc_out        (pc_out),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_target(input logic [15:0] pc, input logic [15:0] t);
`ifdef PC_REL_BRANCH_EN
        return pc + t;
`else
        return t;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        jump_op = 3'd0;
        step();
        total_cnt++;
        if (pc_out !== 16'h0000) $display("FAIL reset_pc actual=%h required=%h", pc_out, 16'h0000);
        else pass_cnt++;
        $display("reset: pc_out=%h", pc_out);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            total_cnt++;
            if (pc_out !== 16'(i)) $display("FAIL seq_pc%0d actual=%h required=%h", i, pc_out, 16'(i));
            else pass_cnt++;
            $display("advance: pc_out=%h", pc_out);
        end
        pc_model = 16'h0003;
    endtask

    task automatic test_alu();
        logic [3:0]  op_t  [15] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                    4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
        logic [15:0] a_t   [15] = '{16'h7FFF, 16'h1234, 16'h0000, 16'hF0F0, 16'hF0F0, 16'hFFFF, 16'h00FF, 16'h0001,
                                    16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h1234, 16'hFFFF};
        logic [15:0] b_t   [15] = '{16'h0001, 16'h1234, 16'h0001, 16'h3C3C, 16'h0F00, 16'h1234, 16'h0000, 16'h0014,
                                    16'h000F, 16'h0013, 16'h0001, 16'h0001, 16'hABCD, 16'h5678, 16'hFFFF};
        logic [15:0] r_t   [15] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h3030, 16'hFFF0, 16'hEDCB, 16'hFF00, 16'h0010,
                                    16'h0001, 16'hF000, 16'h0001, 16'h0000, 16'hABCD, 16'h0000, 16'h0000};
        for (int i = 0; i < 15; i++) begin
            alu_ctrl = op_t[i];
            alu_a    = a_t[i];
            alu_b    = b_t[i];
            #1;
            total_cnt++;
            if (alu_result !== r_t[i])
                $display("FAIL alu_result[%0d] op=%0d actual=%h required=%h", i, op_t[i], alu_result, r_t[i]);
            else pass_cnt++;
            total_cnt++;
            if (alu_zero !== (r_t[i] == 16'h0000))
                $display("FAIL alu_zero[%0d] actual=%b required=%b", i, alu_zero, (r_t[i] == 16'h0000));
            else pass_cnt++;
            $display("alu op=%0d a=%h b=%h result=%h zero=%b", op_t[i], a_t[i], b_t[i], alu_result, alu_zero);
        end
    endtask

    task automatic test_branch();
        logic [2:0]  op_t [11] = '{3'd4, 3'd6, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd5, 3'd5, 3'd7};
        logic [15:0] a_t  [11] = '{16'hFFFE, 16'hFFFE, 16'h0005, 16'h0000, 16'h0007, 16'h0007,
                                   16'h0007, 16'h0009, 16'hFFFE, 16'h0002, 16'hFFFE};
        logic [15:0] b_t  [11] = '{16'h0002, 16'h0002, 16'h0005, 16'h0001, 16'h0007, 16'h0008,
                                   16'h0008, 16'h0009, 16'h0002, 16'h0002, 16'h0002};
        logic        tk_t [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] t_t  [11] = '{16'h0040, 16'h0200, 16'h0300, 16'h0100, 16'h0020,
                                   16'h0400, 16'h0055, 16'h0500, 16'h0600, 16'h0077, 16'h0033};
        logic [15:0] exp_tgt;
        for (int i = 0; i < 11; i++) begin
            jump_op   = op_t[i];
            cmp_a     = a_t[i];
            cmp_b     = b_t[i];
            target_in = t_t[i];
            exp_tgt   = exp_target(pc_model, t_t[i]);
            #1;
            total_cnt++;
            if (branch_taken !== tk_t[i])
                $display("FAIL taken[%0d] op=%0d actual=%b required=%b", i, op_t[i], branch_taken, tk_t[i]);
            else pass_cnt++;
            total_cnt++;
            if (branch_target !== exp_tgt)
                $display("FAIL target[%0d] actual=%h required=%h", i, branch_target, exp_tgt);
            else pass_cnt++;
            step();
            pc_model = tk_t[i] ? exp_tgt : pc_model + 16'd1;
            total_cnt++;
            if (pc_out !== pc_model)
                $display("FAIL branch_pc[%0d] actual=%h required=%h", i, pc_out, pc_model);
            else pass_cnt++;
            $display("branch op=%0d a=%h b=%h taken=%b pc_out=%h", op_t[i], a_t[i], b_t[i], branch_taken, pc_out);
        end
        jump_op = 3'd0;
    endtask

    task automatic test_reset_wins();
        rst       = 1'b0;
        jump_op   = 3'd1;
        target_in = 16'h0100;
        step();
        total_cnt++;
        if (pc_out !== 16'h0000) $display("FAIL reset_wins actual=%h required=%h", pc_out, 16'h0000);
        else pass_cnt++;
        $display("reset with JMP: pc_out=%h", pc_out);
        rst      = 1'b1;
        pc_model = 16'h0000;
    endtask

    // From pc 0, absolute and PC-relative targets coincide, so this reaches FFFF in either build.
    task automatic test_wrap();
        jump_op   = 3'd1;
        target_in = 16'hFFFF;
        step();
        total_cnt++;
        if (pc_out !== 16'hFFFF) $display("FAIL jump_ffff actual=%h required=%h", pc_out, 16'hFFFF);
        else pass_cnt++;
        jump_op = 3'd0;
        step();
        total_cnt++;
        if (pc_out !== 16'h0000) $display("FAIL wrap actual=%h required=%h", pc_out, 16'h0000);
        else pass_cnt++;
        $display("wrap: pc_out=%h", pc_out);
        pc_model = 16'h0000;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_pc;
        jump_op   = 3'd1;
        target_in = 16'h0010;
        step();
        total_cnt++;
        if (pc_out !== 16'h0010) $display("FAIL jump_0010 actual=%h required=%h", pc_out, 16'h0010);
        else pass_cnt++;
        target_in = 16'hFFFC;
`ifdef PC_REL_BRANCH_EN
        exp_pc = 16'h000C;
`else
        exp_pc = 16'hFFFC;
`endif
        step();
        total_cnt++;
        if (pc_out !== exp_pc) $display("FAIL jump_fffc actual=%h required=%h", pc_out, exp_pc);
        else pass_cnt++;
        $display("back-to-back JMP: pc_out=%h", pc_out);
        jump_op = 3'd0;
        step();
        total_cnt++;
        if (pc_out !== exp_pc + 16'd1) $display("FAIL after_jump actual=%h required=%h", pc_out, exp_pc + 16'd1);
        else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b0;
        alu_ctrl  = 4'd0;
        alu_a     = 16'h0000;
        alu_b     = 16'h0000;
        jump_op   = 3'd0;
        cmp_a     = 16'h0000;
        cmp_b     = 16'h0000;
        target_in = 16'h0000;
        pc_model  = 16'h0000;
        @(negedge clk);
        test_reset();
        test_alu();
        test_branch();
        test_reset_wins();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
